// File: rtl/bcd_count_chain_pkg.sv
// Shared definitions for the BCD counter chain: digit width, digit constants
// and helpers that extract or clamp one digit against its terminal value.
package bcd_count_chain_pkg;

  localparam int unsigned DIG_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned ALL_W      = DIG_W * MAX_DIGITS;

  typedef logic [DIG_W-1:0] bcd_digit_t;

  localparam bcd_digit_t DIG_ZERO = 4'd0;
  localparam bcd_digit_t DIG_ONE  = 4'd1;

  function automatic bcd_digit_t dig_max(input logic [ALL_W-1:0] packed_max,
                                         input int unsigned      k);
    return packed_max[k*DIG_W +: DIG_W];
  endfunction

  // Values above the digit maximum (including non-BCD nibbles) pin to the maximum
  function automatic bcd_digit_t dig_clamp(input bcd_digit_t value,
                                           input bcd_digit_t max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/bcd_count_chain_digit.sv
// One BCD digit of the chain: clear/load/step/hold with its own terminal value,
// reporting whether it currently sits at its maximum or at zero.
module bcd_count_chain_digit
  import bcd_count_chain_pkg::*;
(
  input  logic       clk,
  input  logic       init,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       step,
  input  logic       up,
  input  bcd_digit_t max,
  output bcd_digit_t digit,
  output logic       at_max,
  output logic       at_zero
);

  bcd_digit_t digit_r;
  bcd_digit_t digit_nxt_s;

  // Next digit value in priority order clear, load, step, hold
  always_comb begin
    digit_nxt_s = digit_r;
    if (clr) begin
      digit_nxt_s = DIG_ZERO;
    end else if (load) begin
      digit_nxt_s = dig_clamp(load_val, max);
    end else if (step) begin
      if (up) begin
        digit_nxt_s = (digit_r == max) ? DIG_ZERO : digit_r + DIG_ONE;
      end else begin
        digit_nxt_s = (digit_r == DIG_ZERO) ? max : digit_r - DIG_ONE;
      end
    end else begin
      digit_nxt_s = digit_r;
    end
  end

  // Digit state register with synchronous reset
  always_ff @(posedge clk) begin
    if (init) begin
      digit_r <= DIG_ZERO;
    end else begin
      digit_r <= digit_nxt_s;
    end
  end

  assign digit   = digit_r;
  assign at_max  = (digit_r == max);
  assign at_zero = (digit_r == DIG_ZERO);

endmodule

// File: rtl/bcd_count_chain.sv
// Multi-digit BCD counter chain with per-digit terminal values, up/down,
// load, soft clear and wrap/saturate behaviour at terminal count.
module bcd_count_chain
  import bcd_count_chain_pkg::*;
#(
  parameter int unsigned               P_DIGITS  = 4,
  parameter logic [4*P_DIGITS-1:0]     P_DIG_MAX = 16'h5959,
  parameter bit                        P_WRAP    = 1'b1
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic                  en_i,
  input  logic                  up_i,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [4*P_DIGITS-1:0] load_val,
  output logic [4*P_DIGITS-1:0] count,
  output logic                  tc_o,
  output logic                  en_o
);

  localparam logic [ALL_W-1:0] MAX_ALL_C = ALL_W'(P_DIG_MAX);

  logic [P_DIGITS-1:0] at_max_s;
  logic [P_DIGITS-1:0] at_zero_s;
  logic [P_DIGITS-1:0] term_s;
  logic [P_DIGITS-1:0] step_s;
  logic                tc_s;
  logic                adv_s;

  // A digit is terminal when it sits at the end it would roll over from
  assign term_s = up_i ? at_max_s : at_zero_s;
  assign tc_s   = &term_s;

  // In saturate mode a step at terminal count is swallowed for the whole chain
  assign adv_s  = en_i & ~(~P_WRAP & tc_s);

  assign tc_o   = tc_s;
  assign en_o   = en_i & tc_s & P_WRAP;

  for (genvar k = 0; k < P_DIGITS; k++) begin : g_digit
    // Carry lookahead: each digit sees the AND of all lower terminal flags directly
    if (k == 0) begin : g_lsd
      assign step_s[k] = adv_s;
    end else begin : g_upper
      assign step_s[k] = adv_s & (&term_s[k-1:0]);
    end

    bcd_count_chain_digit u_digit (
      .clk      (clk),
      .init     (init),
      .clr      (clr_i),
      .load     (load_i),
      .load_val (load_val[k*DIG_W +: DIG_W]),
      .step     (step_s[k]),
      .up       (up_i),
      .max      (dig_max(MAX_ALL_C, k)),
      .digit    (count[k*DIG_W +: DIG_W]),
      .at_max   (at_max_s[k]),
      .at_zero  (at_zero_s[k])
    );
  end

endmodule

// File: tb/tb_bcd_count_chain.sv
// Scoreboard bench for bcd_count_chain: a wrapping and a saturating instance
// share stimulus and are compared against a mixed-radix integer model.
`timescale 1ns/1ps
module tb_bcd_count_chain;

  localparam logic [15:0] DMAX = 16'h5959;
  localparam int          NVAL = 10 * 6 * 10 * 6;

  logic        clk = 1'b0;
  logic        init = 1'b0, en_i = 1'b0, up_i = 1'b1, clr_i = 1'b0, load_i = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] count_w, count_s;
  logic        tc_w, tc_s, eo_w, eo_s;

  bcd_count_chain #(.P_DIGITS(4), .P_DIG_MAX(16'h5959), .P_WRAP(1'b1)) dut_w (
    .clk(clk), .init(init), .en_i(en_i), .up_i(up_i), .clr_i(clr_i),
    .load_i(load_i), .load_val(load_val), .count(count_w), .tc_o(tc_w), .en_o(eo_w));

  bcd_count_chain #(.P_DIGITS(4), .P_DIG_MAX(16'h5959), .P_WRAP(1'b0)) dut_s (
    .clk(clk), .init(init), .en_i(en_i), .up_i(up_i), .clr_i(clr_i),
    .load_i(load_i), .load_val(load_val), .count(count_s), .tc_o(tc_s), .en_o(eo_s));

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] cnt_w, cnt_s;
    logic        tc_w, tc_s, eo_w, eo_s;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   v_w      = 0;
  int   v_s      = 0;
  bit   known    = 1'b0;

  // Radix of digit k is its maximum plus one
  function automatic int radix(input int k);
    logic [15:0] m;
    m = DMAX;
    return int'(m[4*k +: 4]) + 1;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = 16'h0000;
    t = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(t % radix(k));
      t = t / radix(k);
    end
    return r;
  endfunction

  function automatic int load_to_val(input logic [15:0] lv);
    int v, w, d;
    v = 0;
    w = 1;
    for (int k = 0; k < 4; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > radix(k) - 1) d = radix(k) - 1;
      v = v + d * w;
      w = w * radix(k);
    end
    return v;
  endfunction

  function automatic bit tc_of(input int v, input bit u);
    return u ? (v == NVAL - 1) : (v == 0);
  endfunction

  function automatic int next_val(input int v, input bit wrap, input bit i, input bit c,
                                  input bit l, input logic [15:0] lv, input bit e, input bit u);
    if (i || c) return 0;
    if (l) return load_to_val(lv);
    if (!e) return v;
    if (!wrap && tc_of(v, u)) return v;
    return u ? (v + 1) % NVAL : (v + NVAL - 1) % NVAL;
  endfunction

  task automatic drive(input bit i, input bit c, input bit l, input logic [15:0] lv,
                       input bit e, input bit u);
    exp_t x;
    @(posedge clk);
    #1;
    init = i; clr_i = c; load_i = l; load_val = lv; en_i = e; up_i = u;
    cyc++;
    if (known) begin
      x.cyc   = cyc;
      x.cnt_w = to_bcd(v_w);
      x.cnt_s = to_bcd(v_s);
      x.tc_w  = tc_of(v_w, u);
      x.tc_s  = tc_of(v_s, u);
      x.eo_w  = e & tc_of(v_w, u);
      x.eo_s  = 1'b0;
      sb_q.push_back(x);
    end
    v_w = next_val(v_w, 1'b1, i, c, l, lv, e, u);
    v_s = next_val(v_s, 1'b0, i, c, l, lv, e, u);
    if (i) known = 1'b1;
  endtask

  task automatic chk(input string nm, input int cy, input logic [15:0] got,
                     input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cy, got, exp);
    end
  endtask

  // Monitor: compare every presented output cycle against the queued expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("count_wrap", mon_e.cyc, count_w, mon_e.cnt_w);
      chk("tc_wrap",    mon_e.cyc, {15'd0, tc_w}, {15'd0, mon_e.tc_w});
      chk("en_o_wrap",  mon_e.cyc, {15'd0, eo_w}, {15'd0, mon_e.eo_w});
      chk("count_sat",  mon_e.cyc, count_s, mon_e.cnt_s);
      chk("tc_sat",     mon_e.cyc, {15'd0, tc_s}, {15'd0, mon_e.tc_s});
      chk("en_o_sat",   mon_e.cyc, {15'd0, eo_s}, {15'd0, mon_e.eo_s});
    end
  end

  initial begin
    bit          u;
    bit          i, c, l, e;
    logic [15:0] lv;
    int          sel;

    // Reset, then three up steps
    drive(1, 0, 0, 16'h0000, 0, 1);
    drive(1, 0, 0, 16'h0000, 0, 1);
    drive(0, 0, 0, 16'h0000, 0, 0);
    repeat (3) drive(0, 0, 0, 16'h0000, 1, 1);
    drive(0, 0, 0, 16'h0000, 0, 1);
    // Wrap through terminal count upward
    drive(0, 0, 1, 16'h5958, 0, 1);
    repeat (2) drive(0, 0, 0, 16'h0000, 1, 1);
    drive(0, 0, 0, 16'h0000, 0, 1);
    // Downward wrap and borrow across digits
    drive(0, 1, 0, 16'h0000, 0, 0);
    drive(0, 0, 0, 16'h0000, 1, 0);
    drive(0, 0, 1, 16'h1000, 0, 0);
    drive(0, 0, 0, 16'h0000, 1, 0);
    drive(0, 0, 0, 16'h0000, 0, 0);
    // Clamped load, and load beating a simultaneous enable
    drive(0, 0, 1, 16'hFA7C, 0, 1);
    drive(0, 0, 1, 16'h0123, 1, 1);
    drive(0, 0, 0, 16'h0000, 0, 1);
    // Saturation at terminal, released by direction change
    drive(0, 0, 1, 16'h5959, 0, 1);
    repeat (5) drive(0, 0, 0, 16'h0000, 1, 1);
    drive(0, 0, 0, 16'h0000, 1, 0);
    drive(0, 0, 0, 16'h0000, 0, 0);
    // init over clr/load, and clr over en
    drive(0, 0, 1, 16'h1234, 0, 1);
    drive(1, 1, 1, 16'h4321, 1, 1);
    drive(0, 0, 1, 16'h1234, 0, 1);
    drive(0, 1, 0, 16'h0000, 1, 1);
    drive(0, 0, 0, 16'h0000, 0, 1);

    // Randomised phase with biased loads near the terminal values
    u = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) u = ~u;
      i = ($urandom_range(0, 99) == 0);
      c = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       lv = 16'h5958;
        1:       lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
      drive(i, c, l, lv, e, u);
    end
    drive(0, 0, 0, 16'h0000, 0, 1);

    repeat (4) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
